// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   - RV32 opcode constants used by the decoder and the operand-select logic
//   - forwarding mux encodings (FWD_REG / FWD_ALU / FWD_LOAD)
//   - controller FSM state type
//   - default bubble instruction (addi x0, x0, 0)
package pipe_hazard_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_ALU  = 2'b10;
    localparam logic [1:0] FWD_LOAD = 2'b11;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StFlush,
        StLdStall
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bus of the hazard controller.
//   if_inst    : instruction leaving fetch (into stage 2)
//   br_taken   : stage-3 branch/jump resolved taken
//   mem_busy   : data memory not ready, freezes the pipeline
//   id_inst    : tracked stage-2 instruction
//   ex_inst    : tracked stage-3 instruction
//   stall_if   : hold PC and fetch register
//   stall_ex   : hold stage-3 registers
//   rs1_fwd/rs2_fwd : operand bypass selects
//   a_sel/b_sel     : ALU operand selects
//   bubble_cnt : saturating count of injected bubbles
// master = pipeline (drives if_inst/br_taken/mem_busy), slave = controller.
interface pipe_hazard_ctrl_if;
    logic [31:0] if_inst;
    logic        br_taken;
    logic        mem_busy;
    logic [31:0] id_inst;
    logic [31:0] ex_inst;
    logic        stall_if;
    logic        stall_ex;
    logic [1:0]  rs1_fwd;
    logic [1:0]  rs2_fwd;
    logic        a_sel;
    logic        b_sel;
    logic [15:0] bubble_cnt;

    modport master (
        output if_inst, br_taken, mem_busy,
        input  id_inst, ex_inst, stall_if, stall_ex, rs1_fwd, rs2_fwd, a_sel, b_sel,
               bubble_cnt
    );

    modport slave (
        input  if_inst, br_taken, mem_busy,
        output id_inst, ex_inst, stall_if, stall_ex, rs1_fwd, rs2_fwd, a_sel, b_sel,
               bubble_cnt
    );
endinterface

// File: rtl/inst_fields.sv
// Register-usage decode of one RV32 instruction.
//   inst    : instruction word
//   opcode  : inst[6:0]
//   rd/rs1/rs2 : register index fields
//   has_rd  : writes a destination (not BRANCH/STORE)
//   has_rs1 : reads rs1 (not LUI/AUIPC/JAL)
//   has_rs2 : reads rs2 (R-type, STORE, BRANCH only)
module inst_fields
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        has_rd,
    output logic        has_rs1,
    output logic        has_rs2
);

    // funct3/funct7/imm bits play no part in hazard detection
    logic unused_bits;
    assign unused_bits = ^{inst[31:25], inst[14:12]};

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign has_rd  = !((opcode == OPC_BRANCH) || (opcode == OPC_STORE));
    assign has_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign has_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 3-stage in-order pipeline.
// Tracks the stage-2 (id) and stage-3 (ex) instructions, produces bypass and
// ALU operand selects, freezes on mem_busy, squashes after a taken branch and
// counts injected bubbles.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pipe_hazard_ctrl_if.slave (see interface file for signal list)
// Parameters:
//   NOP_INST     : bubble instruction
//   FLUSH_CYCLES : 1..3, fetch slots squashed after a taken branch
// Build option:
//   LOAD_USE_STALL_EN : when defined, a load-use pair stalls one cycle instead
//                       of bypassing load data (FWD_LOAD is never produced).
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP_INST     = NOP_INST_DEF,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input logic              clk,
    input logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES);

    state_e      state_q, state_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ex_q, ex_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic        bubble_inc;

    // Decode of the two tracked stages
    logic [6:0] id_opcode, ex_opcode;
    logic [4:0] id_rd, id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2;
    logic       id_has_rd, id_has_rs1, id_has_rs2;
    logic       ex_has_rd, ex_has_rs1, ex_has_rs2;

    inst_fields u_id_fields (
        .inst    (id_q),
        .opcode  (id_opcode),
        .rd      (id_rd),
        .rs1     (id_rs1),
        .rs2     (id_rs2),
        .has_rd  (id_has_rd),
        .has_rs1 (id_has_rs1),
        .has_rs2 (id_has_rs2)
    );

    inst_fields u_ex_fields (
        .inst    (ex_q),
        .opcode  (ex_opcode),
        .rd      (ex_rd),
        .rs1     (ex_rs1),
        .rs2     (ex_rs2),
        .has_rd  (ex_has_rd),
        .has_rs1 (ex_has_rs1),
        .has_rs2 (ex_has_rs2)
    );

    // Consumer side only needs sources of id and destination of ex
    logic unused_fields;
    assign unused_fields = ^{id_rd, id_has_rd, ex_rs1, ex_rs2, ex_has_rs1, ex_has_rs2};

    logic rs1_match, rs2_match, ex_is_load;
    assign rs1_match  = ex_has_rd && id_has_rs1 && (ex_rd == id_rs1) && (ex_rd != 5'd0);
    assign rs2_match  = ex_has_rd && id_has_rs2 && (ex_rd == id_rs2) && (ex_rd != 5'd0);
    assign ex_is_load = (ex_opcode == OPC_LOAD);

    // Encoding used when the producer in ex is a load
    logic [1:0] load_fwd;
    logic       ld_stall_req;
`ifdef LOAD_USE_STALL_EN
    // The stall removes the pair, so load data is never bypassed
    assign load_fwd     = FWD_REG;
    assign ld_stall_req = (state_q == StRun) && !bus.mem_busy && !bus.br_taken &&
                          ex_is_load && (rs1_match || rs2_match);
`else
    assign load_fwd     = FWD_LOAD;
    assign ld_stall_req = 1'b0;
`endif

    // Selects: zero-latency function of the registered id/ex instructions
    always_comb begin
        bus.rs1_fwd = FWD_REG;
        bus.rs2_fwd = FWD_REG;
        if (rs1_match) bus.rs1_fwd = ex_is_load ? load_fwd : FWD_ALU;
        if (rs2_match) bus.rs2_fwd = ex_is_load ? load_fwd : FWD_ALU;
        bus.a_sel = (id_opcode == OPC_AUIPC) || (id_opcode == OPC_JAL) ||
                    (id_opcode == OPC_BRANCH);
        bus.b_sel = (id_opcode != OPC_OP);
    end

    // Load-use stall is raised in the hazard cycle itself so fetch holds the
    // instruction that would otherwise be overwritten while id is held.
    assign bus.stall_if = (state_q == StMemWait) || ld_stall_req;
    assign bus.stall_ex = (state_q == StMemWait);

    // Next-state logic; priority mem_busy > br_taken > load-use
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        ex_d        = ex_q;
        flush_cnt_d = flush_cnt_q;
        bubble_inc  = 1'b0;

        unique case (state_q)
            StRun, StLdStall: begin
                if (bus.mem_busy) begin
                    state_d = StMemWait;
                end else if (bus.br_taken) begin
                    state_d     = StFlush;
                    id_d        = NOP_INST;
                    ex_d        = NOP_INST;
                    flush_cnt_d = FlushInit;
                end else if (ld_stall_req) begin
                    state_d    = StLdStall;
                    ex_d       = NOP_INST;
                    bubble_inc = 1'b1;
                end else begin
                    state_d = StRun;
                    ex_d    = id_q;
                    id_d    = bus.if_inst;
                end
            end
            StMemWait: begin
                if (!bus.mem_busy) begin
                    // A branch resolved during the wait is taken on exit
                    if (bus.br_taken) begin
                        state_d     = StFlush;
                        id_d        = NOP_INST;
                        ex_d        = NOP_INST;
                        flush_cnt_d = FlushInit;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StFlush: begin
                // Only bubbles occupy id/ex here, so busy/branch cannot arise
                id_d        = NOP_INST;
                ex_d        = NOP_INST;
                bubble_inc  = 1'b1;
                flush_cnt_d = flush_cnt_q - 2'd1;
                if (flush_cnt_q <= 2'd1) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_inc && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            id_q         <= NOP_INST;
            ex_q         <= NOP_INST;
            flush_cnt_q  <= 2'd0;
            bubble_cnt_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            ex_q         <= ex_d;
            flush_cnt_q  <= flush_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.id_inst    = id_q;
    assign bus.ex_inst    = ex_q;
    assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h0000_0013, instruction injected as bubble.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, range 1..3, cycles squashed after a taken branch or jump.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_inst  in  32  instruction leaving fetch, entering stage 2.
REQ-006 SHALL have port br_taken  in  1  stage-3 branch or jump resolved taken.
REQ-007 SHALL have port mem_busy  in  1  data memory not ready; freezes the pipeline.
REQ-008 SHALL have port id_inst / ex_inst  out  32 each  tracked stage-2 / stage-3 instructions.
REQ-009 SHALL have port stall_if  out  1  hold PC and the fetch register.
REQ-010 SHALL have port stall_ex  out  1  hold stage-3 registers.
REQ-011 SHALL have port rs1_fwd / rs2_fwd  out  2 each  encoding: 00 regfile, 10 stage-3 ALU result, 11 stage-3 load data.
REQ-012 SHALL have port a_sel / b_sel  out  1 each  a_sel: 0 rs1, 1 PC; b_sel: 0 rs2, 1 immediate.
REQ-013 SHALL have port bubble_cnt  out  16  saturating count of injected bubbles.

Function
REQ-014 SHALL decode has_rd as false for BRANCH and STORE, and true otherwise.
REQ-015 SHALL decode has_rs1 as false for LUI, AUIPC and JAL.
REQ-016 SHALL decode has_rs2 as true only for R-type, STORE and BRANCH.
REQ-017 SHALL set rsN_fwd nonzero only when ex has_rd, id has_rsN, the register indices match, and ex rd != x0.
  - ex opcode LOAD gives 11.
  - any other opcode gives 10.
REQ-018 SHALL drive a_sel=1 for AUIPC, JAL and BRANCH, else 0.
REQ-019 SHALL drive b_sel=0 for R-type only, else 1.
REQ-020 SHALL compute all selects combinationally from the registered id_inst/ex_inst, with zero latency.
REQ-021 SHALL implement FSM states RUN, MEM_WAIT, FLUSH, LD_STALL; priority order: mem_busy > br_taken > load-use.
REQ-022 RUN:
  - advance: ex_inst<=id_inst, id_inst<=if_inst.
  - mem_busy -> MEM_WAIT.
  - br_taken -> FLUSH.
REQ-023 MEM_WAIT:
  - stall_if=stall_ex=1; id_inst and ex_inst held.
  - return to RUN on the first cycle mem_busy=0.
  - a br_taken held across the wait is acted on in that cycle.
REQ-024 FLUSH:
  - on entry, id_inst<=NOP_INST and ex_inst<=NOP_INST.
  - for FLUSH_CYCLES cycles, if_inst is replaced by NOP_INST; a down-counter tracks these cycles.
  - then RUN.
  - each squashed slot increments bubble_cnt.
REQ-025 bubble_cnt SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-026 On rst_n low, asynchronously:
  - state=RUN.
  - id_inst=ex_inst=NOP_INST.
  - flush counter=0, bubble_cnt=0.
  - stall_if=stall_ex=0.
  - selects follow REQ-017..019 for NOP (00,00,0,1).
REQ-027 Reset asserted in any state, including mid-MEM_WAIT or mid-FLUSH, SHALL abandon that state with no residual stall.

Configuration
REQ-028 Without LOAD_USE_STALL_EN, a load-use match SHALL forward 11 with no stall; LD_STALL is unreachable.
REQ-029 With LOAD_USE_STALL_EN, a load-use match in RUN SHALL go to LD_STALL for one cycle:
  - stall_if=1, id_inst held, ex_inst<=NOP_INST, bubble_cnt+1.
  - then RUN; selects are never 11.

Structure
REQ-030 A shared package SHALL hold the opcode constants, the fwd encodings (FWD_REG, FWD_ALU, FWD_LOAD), the FSM state enum, and the NOP value.
REQ-031 Decode (has_rd/has_rs1/has_rs2/rd/rs1/rs2) SHALL live in one sub-module, inst_fields, instantiated twice (id, ex).

Verification
REQ-032 ex=0x002082B3 (add x5,x1,x2), id=0x00128313 (addi x6,x5,1) -> rs1_fwd=10, rs2_fwd=00, a_sel=0, b_sel=1.
REQ-033 ex=0x0000A283 (lw x5,0(x1)), id=0x00228333 (add x6,x5,x2):
  - macro off: rs1_fwd=11, stall_if=0.
  - macro on: one cycle stall_if=1, ex_inst=0x00000013, next cycle rs1_fwd=00, bubble_cnt=1.
REQ-034 ex=0x00500013 (addi x0,x0,5), id=0x00000093 (addi x1,x0,0) -> rs1_fwd=00.
REQ-035 br_taken=1 together with mem_busy=1 for 3 cycles:
  - stall_if=stall_ex=1 for 3 cycles.
  - then FLUSH; id_inst=ex_inst=0x00000013.
  - bubble_cnt +FLUSH_CYCLES.
REQ-036 rst_n low mid-MEM_WAIT -> immediately state RUN, stall_if=0, id_inst=ex_inst=0x00000013; bubble_cnt forced to FFFF then one more bubble stays FFFF.
